// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back, plus the ALU decoder.
// Control outputs are registered alongside the state. They are loaded from the
// decode of the next state, so they always match the current state. PCEn folds
// in the live zero flag. ALUControl folds in the live funct field.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;

  // Moore output decode for a given state; codes 12-15 drive nothing.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      ADDIWB: c.reg_write = 1'b1;
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; opcode is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   next_state = MEMWB;
      EXEC:    next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // State register with registered Moore outputs; reset forces FETCH outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      ctrl_q <= decode_state(FETCH);
    end else begin
      state  <= next_state;
      ctrl_q <= decode_state(next_state);
    end
  end

  // ALU decoder: ALUOp selects add/sub directly or defers to funct.
  always_comb begin
    ALUControl = 3'b010;
    case (ctrl_q.alu_op)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign IorD     = ctrl_q.iord;
  assign MemWrite = ctrl_q.mem_write;
  assign IRWrite  = ctrl_q.ir_write;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemtoReg = ctrl_q.memto_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ALUSrcB  = ctrl_q.alu_src_b;
  assign PCSrc    = ctrl_q.pc_src;
  assign PCEn     = ctrl_q.pc_write | (ctrl_q.branch & zero);
  assign state_o  = state;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control unit for the multicycle MIPS core: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles of the divided core clock. It also contains the ALU decoder. It sits inside the core between the instruction register fields (opcode, funct), the ALU zero flag, and every datapath mux and write enable.

## Interface
- No parameters. State and ALU encodings are fixed below.
- clk  in  1  core clock (divided clock from the clock divider; the block has no clock-enable of its own)
- rst  in  1  asynchronous reset, active-high; forces state to FETCH
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag of the current cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory/GPIO write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  register write address: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load = PCWrite | (Branch & zero)
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  4  current state, for debug/LEDs

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are illegal and return to FETCH on the next edge.
- Asserted outputs per state (all unlisted outputs are 0; ALUOp is internal):
  - FETCH: IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1.
  - DECODE: ALUSrcB=11, ALUOp=00. This precomputes the branch target.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE on opcode:
    - lw 100011 and sw 101011 → MEMADR.
    - R-type 000000 → EXEC.
    - beq 000100 → BRANCH.
    - addi 001000 → ADDIEX.
    - j 000010 → JUMP.
    - Any other opcode → FETCH (executes as a NOP).
  - MEMADR→MEMRD for lw, MEMADR→MEMWR for sw.
  - MEMRD→MEMWB.
  - EXEC→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all → FETCH.
- ALU decoder (combinational):
  - ALUOp 00 → 010.
  - ALUOp 01 → 110.
  - ALUOp 10 decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct → 010.
  - ALUOp 11 is unused → 010.
- Opcode is sampled in DECODE and MEMADR only. The IR is stable there because IRWrite is asserted only in FETCH.

## Timing
- The state register updates on the rising edge of clk. Asynchronous rst clears it to FETCH immediately, without waiting for an edge.
- Outputs are Moore (state only), except PCEn, which includes zero combinationally in BRANCH. ALUControl also depends combinationally on funct in EXEC.
- While rst is high, outputs equal the FETCH values: IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010. The datapath registers are held in reset at the same time, so no write takes effect.
- Cycles per instruction, FETCH through the last state:
  - lw 5.
  - R-type, sw, addi 4.
  - beq, j 3.
  - Unsupported opcode 2.
- Reset asserted mid-instruction: the instruction is abandoned and no further write enables are issued. The first edge after rst falls moves FETCH→DECODE.
- Branch decision: PCEn=zero during the single BRANCH cycle. The PC loads ALUOut (the target from DECODE) on that edge only when zero=1.

## Test plan
- Reset check: pulse rst mid-EXEC, between clock edges. state_o=0 immediately; IRWrite=1, PCEn=1, RegWrite=0.
- lw sequence: opcode=100011 → states 0,1,2,3,4,0. IorD=1 in states 3 and 4 is wrong; IorD=1 only in state 3. MemtoReg=RegWrite=1 only in state 4. MemWrite is never asserted.
- sw and addi: opcode=101011 gives 0,1,2,5,0 with MemWrite=1 only in state 5. opcode=001000 gives 0,1,9,10,0 with RegWrite=1, RegDst=0 in state 10.
- R-type funct sweep: opcode=0 with funct 100000/100010/100100/100101/101010/111111. In EXEC, ALUControl = 010/110/000/001/111/010. ALUWB has RegDst=1, RegWrite=1.
- beq with zero=1 then zero=0: states 0,1,8,0. In state 8, PCSrc=01 and PCEn follows zero (1, then 0); ALUControl=110.
- j and an unsupported opcode: opcode=000010 gives 0,1,11,0 with PCSrc=10, PCEn=1. opcode=111111 gives 0,1,0 with no write enables asserted in DECODE.
